// File: rtl/dual_port_router_pkg.sv
// dual_port_router_pkg: shared modes, port ids, register map, CTRL fields and weight helper
package dual_port_router_pkg;
  typedef enum logic [1:0] {MODE_FIX_A, MODE_FIX_B, MODE_RR, MODE_WRR} mode_e;
  typedef enum logic {PORT_A, PORT_B} port_e;
  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_WEIGHT = 4'h1;
  localparam logic [3:0] ADDR_CNT_A = 4'h2;
  localparam logic [3:0] ADDR_CNT_B = 4'h3;
  localparam logic [3:0] ADDR_CNT_CONFLICT = 4'h4;
  localparam logic [3:0] ADDR_CLEAR = 4'h5;
  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  function automatic logic [3:0] eff_weight(input logic [3:0] w);
    return w == 4'd0 ? 4'd1 : w;
  endfunction
endpackage

// File: rtl/dual_port_router_arbiter_grant.sv
// drr_grant_fsm: conflict winner (win_a) from mode, weights wa/wb, conflict and ctrl_wr; holds rr/wrr state
module drr_grant_fsm
  import dual_port_router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  mode_e      mode,
  input  logic [3:0] wa,
  input  logic [3:0] wb,
  input  logic       conflict,
  input  logic       ctrl_wr,
  output logic       win_a
);
  port_e rr_q, rr_d, own_q, own_d;
  logic [3:0] run_q, run_d, w_own;
  logic [4:0] run_inc;
  logic       flip;
  assign w_own = eff_weight(own_q == PORT_A ? wa : wb);
  assign run_inc = {1'b0, run_q} + 5'd1;
  assign flip = run_inc >= {1'b0, w_own};
  always_comb begin
    rr_d = rr_q;
    own_d = own_q;
    run_d = run_q;
    if (ctrl_wr) begin
      rr_d = PORT_A;
      own_d = PORT_A;
      run_d = '0;
    end else if (conflict && mode == MODE_RR) begin
      rr_d = rr_q == PORT_A ? PORT_B : PORT_A;
    end else if (conflict && mode == MODE_WRR) begin
      own_d = flip ? (own_q == PORT_A ? PORT_B : PORT_A) : own_q;
      run_d = flip ? 4'd0 : run_inc[3:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= PORT_A;
      own_q <= PORT_A;
      run_q <= '0;
    end else begin
      rr_q <= rr_d;
      own_q <= own_d;
      run_q <= run_d;
    end
  end
  assign win_a = mode == MODE_FIX_A ? 1'b1 :
                 mode == MODE_FIX_B ? 1'b0 :
                 mode == MODE_RR    ? rr_q == PORT_A : own_q == PORT_A;
endmodule

// File: rtl/dual_port_router_arbiter.sv
// dual_port_router_arbiter: two byte ports arbitrated onto N_OUT registered lanes, with reg bus (reg_*), grants (ready_*), lanes (data_out/valid_out)
module dual_port_router_arbiter
  import dual_port_router_pkg::*;
#(
  parameter int REG_W = 32,
  parameter int N_OUT = 4,
  localparam int LW = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         reg_addr,
  input  logic [REG_W-1:0]   reg_wdata,
  input  logic               reg_en,
  input  logic               reg_we,
  output logic [REG_W-1:0]   reg_rdata,
  input  logic [7:0]         data_a,
  input  logic [7:0]         data_b,
  input  logic [LW-1:0]      addr_a,
  input  logic [LW-1:0]      addr_b,
  input  logic               valid_a,
  input  logic               valid_b,
  output logic               ready_a,
  output logic               ready_b,
  output logic [N_OUT*8-1:0] data_out,
  output logic [N_OUT-1:0]   valid_out
);
  logic [REG_W-1:0]   ctrl_q, weight_q, cnt_a_q, cnt_b_q, cnt_c_q, rdata_q, rdata_d;
  logic [N_OUT-1:0]   vout_q, vout_d;
  logic [N_OUT*8-1:0] dout_q, dout_d;
  logic               wr, rd, ctrl_wr, clr, en, conflict, win_a;
  mode_e              mode;
  assign wr = reg_en & reg_we;
  assign rd = reg_en & ~reg_we;
  assign ctrl_wr = wr & reg_addr == ADDR_CTRL;
  assign clr = wr & reg_addr == ADDR_CLEAR & reg_wdata[0];
  assign en = ctrl_q[CTRL_EN];
  assign mode = mode_e'(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
  assign conflict = en & valid_a & valid_b & addr_a == addr_b;
  assign ready_a = ~rst & en & valid_a & (~conflict | win_a);
  assign ready_b = ~rst & en & valid_b & (~conflict | ~win_a);
  drr_grant_fsm u_grant (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .wa       (weight_q[3:0]),
    .wb       (weight_q[7:4]),
    .conflict (conflict),
    .ctrl_wr  (ctrl_wr),
    .win_a    (win_a)
  );
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    logic hit_a, hit_b;
    assign hit_a = ready_a & addr_a == LW'(k);
    assign hit_b = ready_b & addr_b == LW'(k);
    assign vout_d[k] = hit_a | hit_b;
    assign dout_d[8*k+:8] = hit_a ? data_a : hit_b ? data_b : dout_q[8*k+:8];
  end
  always_comb begin
    rdata_d = rdata_q;
    if (rd)
      rdata_d = reg_addr == ADDR_CTRL         ? ctrl_q   :
                reg_addr == ADDR_WEIGHT       ? weight_q :
                reg_addr == ADDR_CNT_A        ? cnt_a_q  :
                reg_addr == ADDR_CNT_B        ? cnt_b_q  :
                reg_addr == ADDR_CNT_CONFLICT ? cnt_c_q  : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      weight_q <= REG_W'(8'h11);
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      rdata_q <= '0;
      vout_q <= '0;
      dout_q <= '0;
    end else begin
      if (ctrl_wr) ctrl_q <= reg_wdata & REG_W'(3'h7);
      if (wr && reg_addr == ADDR_WEIGHT) weight_q <= reg_wdata & REG_W'(8'hFF);
      cnt_a_q <= clr ? '0 : cnt_a_q + REG_W'(ready_a);
      cnt_b_q <= clr ? '0 : cnt_b_q + REG_W'(ready_b);
      cnt_c_q <= clr ? '0 : cnt_c_q + REG_W'(conflict);
      rdata_q <= rdata_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
    end
  end
  assign reg_rdata = rdata_q;
  assign valid_out = vout_q;
  assign data_out = dout_q;
endmodule

// File: tb/tb_dual_port_router_arbiter.sv
// tb_dual_port_router_arbiter: scoreboard bench for grants, lane outputs, registers and counters
module tb_dual_port_router_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_en, reg_we;
  logic [7:0]  data_a, data_b;
  logic [1:0]  addr_a, addr_b;
  logic        valid_a, valid_b, ready_a, ready_b;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  typedef struct packed {logic [3:0] v; logic [31:0] d;} out_t;
  out_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] lane_d = '0;
  out_t        e;
  logic [31:0] got, want;
  logic        ea;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dual_port_router_arbiter dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_en(reg_en),
    .reg_we(reg_we), .reg_rdata(reg_rdata), .data_a(data_a), .data_b(data_b),
    .addr_a(addr_a), .addr_b(addr_b), .valid_a(valid_a), .valid_b(valid_b),
    .ready_a(ready_a), .ready_b(ready_b), .data_out(data_out), .valid_out(valid_out)
  );
  task automatic drive(input logic va, input logic [1:0] aa, input logic [7:0] da,
                       input logic vb, input logic [1:0] ab, input logic [7:0] db);
    @(negedge clk);
    valid_a = va; addr_a = aa; data_a = da;
    valid_b = vb; addr_b = ab; data_b = db;
    #1;
  endtask
  task automatic push_exp(input logic ra, input logic rb);
    out_t o;
    o.v = '0;
    if (ra) begin o.v[addr_a] = 1'b1; lane_d[8*addr_a+:8] = data_a; end
    if (rb) begin o.v[addr_b] = 1'b1; lane_d[8*addr_b+:8] = data_b; end
    o.d = lane_d;
    exp_q.push_back(o);
  endtask
  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d; valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk); #1;
    reg_en = 1'b0; reg_we = 1'b0;
  endtask
  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a; valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk); #1;
    reg_en = 1'b0;
    d = reg_rdata;
  endtask
  task automatic test_reset();
    logic [3:0]  ra[7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9};
    logic [31:0] rv[7] = '{32'h0, 32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1; reg_en = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    valid_a = 1'b1; addr_a = 2'd0; data_a = 8'hAA; valid_b = 1'b1; addr_b = 2'd0; data_b = 8'hBB;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({ready_a, ready_b} !== 2'b00) begin n_bad++; $display("FAIL rst_ready got %b want 00", {ready_a, ready_b}); end
    @(negedge clk); rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({valid_out, data_out, reg_rdata} !== 68'h0) begin n_bad++; $display("FAIL rst_out got %h/%h/%h want 0/0/0", valid_out, data_out, reg_rdata); end
    for (int i = 0; i < 7; i++) begin
      rd_q.push_back(rv[i]);
      reg_read(ra[i], got);
      want = rd_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rst_reg[%h] got %h want %h", ra[i], got, want); end
    end
    drive(1, 2'd1, 8'h12, 1, 2'd1, 8'h34);
    n_cmp++; if ({ready_a, ready_b} !== 2'b00) begin n_bad++; $display("FAIL disabled_ready got %b want 00", {ready_a, ready_b}); end
    push_exp(0, 0);
    @(posedge clk); #1; e = exp_q.pop_front();
    n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL disabled_out got %h/%h want %h/%h", valid_out, data_out, e.v, e.d); end
  endtask
  task automatic test_fixed();
    reg_write(4'h0, 32'h1);
    drive(1, 2'd2, 8'h5A, 1, 2'd3, 8'hC3);
    n_cmp++; if ({ready_a, ready_b} !== 2'b11) begin n_bad++; $display("FAIL fixa_ready got %b want 11", {ready_a, ready_b}); end
    push_exp(1, 1);
    @(posedge clk); #1; e = exp_q.pop_front();
    n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL fixa_out got %h/%h want %h/%h", valid_out, data_out, e.v, e.d); end
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    push_exp(0, 0);
    @(posedge clk); #1; e = exp_q.pop_front();
    n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL fixa_idle got %h/%h want %h/%h", valid_out, data_out, e.v, e.d); end
    rd_q.push_back(32'd1); reg_read(4'h2, got); want = rd_q.pop_front();
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL fixa_cnt_a got %h want %h", got, want); end
    rd_q.push_back(32'd1); reg_read(4'h3, got); want = rd_q.pop_front();
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL fixa_cnt_b got %h want %h", got, want); end
    drive(1, 2'd0, 8'h11, 1, 2'd0, 8'h22);
    n_cmp++; if ({ready_a, ready_b} !== 2'b10) begin n_bad++; $display("FAIL fixa_conflict got %b want 10", {ready_a, ready_b}); end
    push_exp(1, 0);
    @(posedge clk); #1; e = exp_q.pop_front();
    n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL fixa_conflict_out got %h/%h want %h/%h", valid_out, data_out, e.v, e.d); end
  endtask
  task automatic test_rr();
    logic [31:0] cv[3] = '{32'd4, 32'd2, 32'd2};
    logic [3:0]  ca[3] = '{4'h4, 4'h2, 4'h3};
    reg_write(4'h5, 32'h1);
    reg_write(4'h0, 32'h5);
    for (int i = 0; i < 4; i++) begin
      ea = (i % 2) == 0;
      drive(1, 2'd1, 8'h10 + 8'(i), 1, 2'd1, 8'h80 + 8'(i));
      n_cmp++; if ({ready_a, ready_b} !== {ea, ~ea}) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, {ready_a, ready_b}, {ea, ~ea}); end
      push_exp(ea, ~ea);
      @(posedge clk); #1; e = exp_q.pop_front();
      n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL rr_out[%0d] got %h/%h want %h/%h", i, valid_out, data_out, e.v, e.d); end
    end
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(cv[i]); reg_read(ca[i], got); want = rd_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rr_cnt[%h] got %h want %h", ca[i], got, want); end
    end
  endtask
  task automatic test_wrr();
    reg_write(4'h1, 32'h13);
    reg_write(4'h0, 32'h7);
    for (int i = 0; i < 8; i++) begin
      ea = (i % 4) != 3;
      drive(1, 2'd0, 8'h20 + 8'(i), 1, 2'd0, 8'hA0 + 8'(i));
      n_cmp++; if ({ready_a, ready_b} !== {ea, ~ea}) begin n_bad++; $display("FAIL wrr_ready[%0d] got %b want %b", i, {ready_a, ready_b}, {ea, ~ea}); end
      push_exp(ea, ~ea);
      @(posedge clk); #1; e = exp_q.pop_front();
      n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL wrr_out[%0d] got %h/%h want %h/%h", i, valid_out, data_out, e.v, e.d); end
    end
    reg_write(4'h1, 32'h00);
    reg_write(4'h0, 32'h7);
    for (int i = 0; i < 4; i++) begin
      ea = (i % 2) == 0;
      drive(1, 2'd3, 8'h30 + 8'(i), 1, 2'd3, 8'hB0 + 8'(i));
      n_cmp++; if ({ready_a, ready_b} !== {ea, ~ea}) begin n_bad++; $display("FAIL wrr0_ready[%0d] got %b want %b", i, {ready_a, ready_b}, {ea, ~ea}); end
      push_exp(ea, ~ea);
      @(posedge clk); #1; e = exp_q.pop_front();
      n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL wrr0_out[%0d] got %h/%h want %h/%h", i, valid_out, data_out, e.v, e.d); end
    end
  endtask
  task automatic test_disable();
    reg_write(4'h0, 32'h3);
    for (int i = 0; i < 5; i++) begin
      ea = i < 3;
      drive(1, 2'd2, 8'h40 + 8'(i), 1, 2'd2, 8'hD0 + 8'(i));
      if (i == 2) begin reg_en = 1'b1; reg_we = 1'b1; reg_addr = 4'h0; reg_wdata = 32'h0; end
      n_cmp++; if ({ready_a, ready_b} !== {1'b0, ea}) begin n_bad++; $display("FAIL dis_ready[%0d] got %b want %b", i, {ready_a, ready_b}, {1'b0, ea}); end
      push_exp(0, ea);
      @(posedge clk); #1; e = exp_q.pop_front();
      reg_en = 1'b0; reg_we = 1'b0;
      n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL dis_out[%0d] got %h/%h want %h/%h", i, valid_out, data_out, e.v, e.d); end
    end
  endtask
  task automatic test_clear_wrap();
    logic [3:0] ca[3] = '{4'h2, 4'h3, 4'h4};
    reg_write(4'h0, 32'h1);
    reg_write(4'h5, 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd0, 8'h50 + 8'(i), 1, 2'd1, 8'hE0 + 8'(i));
      if (i == 3) begin reg_en = 1'b1; reg_we = 1'b1; reg_addr = 4'h5; reg_wdata = 32'h1; end
      n_cmp++; if ({ready_a, ready_b} !== 2'b11) begin n_bad++; $display("FAIL clr_ready[%0d] got %b want 11", i, {ready_a, ready_b}); end
      push_exp(1, 1);
      @(posedge clk); #1; e = exp_q.pop_front();
      reg_en = 1'b0; reg_we = 1'b0;
      n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL clr_out[%0d] got %h/%h want %h/%h", i, valid_out, data_out, e.v, e.d); end
      if (i == 2) begin
        rd_q.push_back(32'd3); reg_read(4'h2, got); want = rd_q.pop_front();
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL clr_pre_cnt_a got %h want %h", got, want); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(32'd0); reg_read(ca[i], got); want = rd_q.pop_front();
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL clr_cnt[%h] got %h want %h", ca[i], got, want); end
    end
    drive(1, 2'd3, 8'hEE, 0, 2'd0, 8'h00);
    force dut.cnt_a_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_a_q;
    n_cmp++; if ({ready_a, ready_b} !== 2'b10) begin n_bad++; $display("FAIL wrap_ready got %b want 10", {ready_a, ready_b}); end
    push_exp(1, 0);
    @(posedge clk); #1; e = exp_q.pop_front();
    n_cmp++; if ({valid_out, data_out} !== {e.v, e.d}) begin n_bad++; $display("FAIL wrap_out got %h/%h want %h/%h", valid_out, data_out, e.v, e.d); end
    rd_q.push_back(32'd0); reg_read(4'h2, got); want = rd_q.pop_front();
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_cnt_a got %h want %h", got, want); end
  endtask
  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_wrr();
    test_disable();
    test_clear_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dual_port_router_arbiter.md
Name: dual_port_router_arbiter

Overview:
- Arbitration and scheduling core for the dual-port router data plane.
- Accepts byte transfers from Port A and Port B, each addressed to one of 4 output lanes.
- Resolves same-lane conflicts using a register-selected policy: fixed-A, fixed-B, round-robin or weighted round-robin.
- Drives registered lane outputs and exposes control/status registers on the simple APB-like register bus.

Parameters:
- REG_W, 32, register data width; counters are REG_W bits.
- N_OUT, 4, number of output lanes; lane address width is $clog2(N_OUT) (2 at default).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_addr  in  4  register address
- reg_wdata  in  REG_W  register write data
- reg_en  in  1  register access strobe
- reg_we  in  1  1 = write, 0 = read
- reg_rdata  out  REG_W  read data, registered
- data_a / data_b  in  8  port payload
- addr_a / addr_b  in  2  destination lane
- valid_a / valid_b  in  1  transfer request
- ready_a / ready_b  out  1  grant; combinational from valid/addr/state
- data_out  out  N_OUT*8  lane k payload in bits [8k+7:8k]
- valid_out  out  N_OUT  lane k valid strobe

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst.
- Reset values: reg_rdata=0, data_out=0, valid_out=0, CTRL=0 (disabled), WEIGHT=0x11, all counters 0, rr_ptr=A, wrr_owner=A, wrr_run=0.
- While rst is high, ready_a and ready_b are 0.
- Registers (word index):
  - 0x0 CTRL RW: [0]=enable; [2:1]=mode (0 fixed-A, 1 fixed-B, 2 RR, 3 WRR).
  - 0x1 WEIGHT RW: [3:0]=wa, [7:4]=wb. A weight of 0 is treated as 1.
  - 0x2 CNT_A RO.
  - 0x3 CNT_B RO.
  - 0x4 CNT_CONFLICT RO.
  - 0x5 CLEAR WO: write with bit0=1 zeroes all three counters.
- Register write: takes effect on the clock edge with reg_en & reg_we. Writes to RO addresses are ignored.
- Register read: reg_en & !reg_we loads reg_rdata on that edge, so data is valid the next cycle. Unmapped addresses return 0. reg_rdata holds its value otherwise.
- Grant rules (evaluated every cycle):
  - enable=0: ready_a = ready_b = 0.
  - Conflict = valid_a & valid_b & (addr_a == addr_b).
  - No conflict: ready_x = valid_x.
  - Conflict: exactly one ready, chosen by mode.
- Ready depends on valid; drivers must not make valid depend on ready.
- Fixed-A / fixed-B: the named port always wins a conflict.
- RR: the rr_ptr port wins; rr_ptr flips after each conflict. Non-conflict cycles leave rr_ptr unchanged.
- WRR: wrr_owner wins, then wrr_run++. When wrr_run reaches the owner's weight, the owner flips and wrr_run=0. Non-conflict cycles leave state unchanged.
- Datapath, 1-cycle latency:
  - Accepted transfer (valid & ready) to lane k: next cycle valid_out[k]=1 and data_out[k]=data.
  - valid_out[k] deasserts the cycle after with no new transfer to lane k.
  - data_out[k] holds its last value.
  - Both ports may hit different lanes in the same cycle.
- Counters:
  - CNT_A / CNT_B increment on each accepted transfer.
  - CNT_CONFLICT increments on each conflict cycle while enabled.
  - Counters wrap modulo 2^REG_W.
  - CLEAR in the same cycle as an increment: clear wins, so the counter is 0.
- Any CTRL write resets rr_ptr=A, wrr_owner=A, wrr_run=0.
- Disable mid-stream: grants stop that cycle. A transfer accepted in the prior cycle still appears on valid_out.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight outputs are dropped.

Decomposition:
- Package dual_port_router_pkg:
  - mode_e enum: MODE_FIX_A, MODE_FIX_B, MODE_RR, MODE_WRR.
  - Register address localparams: ADDR_CTRL..ADDR_CLEAR.
  - CTRL field bit positions.
- Sub-module drr_grant_fsm: holds rr_ptr/wrr state and produces the conflict winner. Inputs: mode, weights, conflict, ctrl_wr.
- Top level holds the register file, counters and output registers.

Test Plan:
- Reset, then read regs 0x0–0x5 -> values 0, 0x11, 0, 0, 0, 0. ready_a and ready_b stay 0 while valid is asserted and enable=0.
- CTRL=0x1 (enable, fixed-A). A: lane 2, 0x5A; B: lane 3, 0xC3, same cycle -> both ready. Next cycle valid_out=4'b1100, lane2=0x5A, lane3=0xC3. CNT_A=CNT_B=1.
- CTRL=0x5 (RR). Both ports target lane 1 for 4 cycles -> grant sequence A,B,A,B. CNT_CONFLICT=4, CNT_A=2, CNT_B=2.
- CTRL=0x7 (WRR), WEIGHT=0x13 (wa=3, wb=1). Conflict on lane 0 for 8 cycles -> A,A,A,B,A,A,A,B.
- CTRL=0x3 (fixed-B), sustained conflict. Write CTRL=0x0 mid-stream -> ready deasserts the same cycle. The last accepted B byte still appears on valid_out the next cycle, then nothing further.
- Counters running, then CLEAR=0x1 during an accepted transfer -> counters read 0. Preload is not possible, so check wrap via a forced CNT_A=0xFFFFFFFF: one more transfer gives 0.
